// File: rtl/wdt_top.sv
// Watchdog timer OBI slave: prescaled down-counter that warns via irq_o on the
// first missed kick and pulses rst_req_o on the second, surviving its own reset.
module wdt_top #(
   parameter int unsigned PRESCALE     = 1,
   parameter logic [31:0] DEFAULT_LOAD = 32'h00FF_FFFF,
   parameter int unsigned RST_PULSE    = 16,
   parameter logic [31:0] KICK_KEY     = 32'h5A5A_A5A5,
   parameter logic [31:0] CLR_KEY      = 32'hC1EA_C1EA
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        irq_o,
   output logic        rst_req_o
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CW = $clog2(RST_PULSE + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] PULSE_LEN = CW'(RST_PULSE);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_LOAD   = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WARN = 2'd2,
      ST_RST  = 2'd3
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     ctrl_q, ctrl_d;
   logic [31:0]    load_q, load_d;
   logic [31:0]    count_q, count_d;
   logic           pend_q, pend_d;
   logic           wdrst_q, wdrst_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [CW-1:0]  pulse_q, pulse_d;
   logic [31:0]    data_q, data_d;
   logic           irq_q, irq_d;
   logic           rst_req_q, rst_req_d;

   logic       wr_en, rd_en;
   logic [1:0] reg_sel;
   logic       wr_ctrl, wr_load, wr_key;
   logic       kick, clr_key, active, tick, expire;
   logic       disable_req, enable_req, enter_run, reload;
   logic       unused_addr;

   // Bus decode: only full-word writes count; reads ignore byte enables.
   assign reg_sel     = addr_i[3:2];
   assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};
   assign wr_en       = req_i & we_i & (be_i == 4'hF);
   assign rd_en       = req_i & ~we_i;
   assign wr_ctrl     = wr_en & (reg_sel == A_CTRL) & ~ctrl_q[3];
   assign wr_load     = wr_en & (reg_sel == A_LOAD) & ~ctrl_q[3];
   assign wr_key      = wr_en & (reg_sel == A_STATUS);
   assign clr_key     = wr_key & (data_i == CLR_KEY);

   assign active      = (state_q == ST_RUN) | (state_q == ST_WARN);
   assign kick        = wr_key & (data_i == KICK_KEY) & active;
   assign tick        = active & (presc_q == PRESC_MAX);
   // A kick landing on the expiry tick suppresses the expiry.
   assign expire      = tick & (count_q == 32'd0) & ~kick;
   assign disable_req = wr_ctrl & ~data_i[0];
   assign enable_req  = wr_ctrl & data_i[0] & (state_q == ST_IDLE);

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first so no path through this block infers a latch.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (enable_req) state_d = ST_RUN;
         ST_RUN: begin
            if (disable_req)  state_d = ST_IDLE;
            else if (expire)  state_d = ST_WARN;
         end
         ST_WARN: begin
            if (disable_req)                state_d = ST_IDLE;
            else if (kick)                  state_d = ST_RUN;
            else if (expire && ctrl_q[2])   state_d = ST_RST;
         end
         ST_RST: begin
            if (disable_req)                state_d = ST_IDLE;
            else if (pulse_q == CW'(1))     state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign enter_run = (state_d == ST_RUN) & (state_q != ST_RUN);
   assign reload    = disable_req | kick | expire | enter_run;

   // Datapath next-state
   always_comb begin
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      presc_d = presc_q;
      pulse_d = pulse_q;
      wdrst_d = wdrst_q;
      data_d  = data_q;

      if (wr_ctrl) ctrl_d = {ctrl_q[3] | data_i[3], data_i[2:0]};
      if (wr_load) load_d = data_i;

      if (reload)    count_d = load_q;
      else if (tick) count_d = count_q - 32'd1;

      if ((state_d != ST_RUN && state_d != ST_WARN) || kick || enter_run || tick)
         presc_d = '0;
      else
         presc_d = presc_q + PW'(1);

      if (state_d == ST_RST && state_q != ST_RST) pulse_d = PULSE_LEN;
      else if (state_q == ST_RST)                 pulse_d = pulse_q - CW'(1);

      // Setting the sticky flag beats a coincident clear.
      if (clr_key)                                wdrst_d = 1'b0;
      if (state_q == ST_WARN && state_d == ST_RST) wdrst_d = 1'b1;

      if (rd_en) begin
         unique case (reg_sel)
            A_CTRL:   data_d = {28'd0, ctrl_q};
            A_LOAD:   data_d = load_q;
            A_COUNT:  data_d = count_q;
            A_STATUS: data_d = {29'd0, wdrst_q, ctrl_q[3], pend_q};
            default:  data_d = '0;
         endcase
      end
   end

   // Output logic: PEND mirrors WARN/RST, outputs registered from next-state values.
   always_comb begin
      pend_d    = (state_d == ST_WARN) | (state_d == ST_RST);
      irq_d     = pend_d & ctrl_d[1];
      rst_req_d = (state_d == ST_RST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q    <= '0;
         load_q    <= DEFAULT_LOAD;
         count_q   <= DEFAULT_LOAD;
         pend_q    <= 1'b0;
         wdrst_q   <= 1'b0;
         presc_q   <= '0;
         pulse_q   <= '0;
         data_q    <= '0;
         irq_q     <= 1'b0;
         rst_req_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         wdrst_q   <= wdrst_d;
         presc_q   <= presc_d;
         pulse_q   <= pulse_d;
         data_q    <= data_d;
         irq_q     <= irq_d;
         rst_req_q <= rst_req_d;
      end
   end

   assign data_o    = data_q;
   assign irq_o     = irq_q;
   assign rst_req_o = rst_req_q;

endmodule

// File: tb/tb_wdt_top.sv
// Directed bench for wdt_top: register table after reset, then hand-written
// expiry, kick, lock, prescaler and mid-pulse reset sequences.
module tb_wdt_top;

   localparam logic [31:0] KICK = 32'h5A5A_A5A5;
   localparam logic [31:0] CLR  = 32'hC1EA_C1EA;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_m, req_p, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic [31:0] dout_m, dout_p;
   logic        irq_m, irq_p, rreq_m, rreq_p;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   wdt_top u_dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_m), .we_i(we), .be_i(be),
      .addr_i(addr), .data_i(wdata), .data_o(dout_m), .irq_o(irq_m), .rst_req_o(rreq_m)
   );

   wdt_top #(.PRESCALE(4)) u_dut_p4 (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_p), .we_i(we), .be_i(be),
      .addr_i(addr), .data_i(wdata), .data_o(dout_p), .irq_o(irq_p), .rst_req_o(rreq_p)
   );

   typedef struct {
      bit          wr;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input bit sel, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] b);
      we = 1'b1; addr = {28'd0, a}; wdata = d; be = b;
      if (sel) req_p = 1'b1; else req_m = 1'b1;
      @(posedge clk); #1;
      req_m = 1'b0; req_p = 1'b0; we = 1'b0;
   endtask

   task automatic bus_rd(input bit sel, input logic [3:0] a, output logic [31:0] d);
      we = 1'b0; addr = {28'd0, a}; be = 4'hF;
      if (sel) req_p = 1'b1; else req_m = 1'b1;
      @(posedge clk); #1;
      req_m = 1'b0; req_p = 1'b0;
      d = sel ? dout_p : dout_m;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      int          n_high;
      bit          found;

      vecs[0]  = '{0, 4'h0, 32'h0,         4'hF, 32'h0000_0000};
      vecs[1]  = '{0, 4'h4, 32'h0,         4'hF, 32'h00FF_FFFF};
      vecs[2]  = '{0, 4'h8, 32'h0,         4'hF, 32'h00FF_FFFF};
      vecs[3]  = '{0, 4'hC, 32'h0,         4'hF, 32'h0000_0000};
      vecs[4]  = '{1, 4'h4, 32'h0000_1234, 4'h3, 32'h0};
      vecs[5]  = '{0, 4'h4, 32'h0,         4'hF, 32'h00FF_FFFF};
      vecs[6]  = '{1, 4'h8, 32'h0000_0055, 4'hF, 32'h0};
      vecs[7]  = '{0, 4'h8, 32'h0,         4'hF, 32'h00FF_FFFF};
      vecs[8]  = '{1, 4'h4, 32'h0000_0003, 4'hF, 32'h0};
      vecs[9]  = '{0, 4'h4, 32'h0,         4'hF, 32'h0000_0003};
      vecs[10] = '{0, 4'h8, 32'h0,         4'hF, 32'h00FF_FFFF};
      vecs[11] = '{1, 4'h0, 32'h0000_0006, 4'hF, 32'h0};
      vecs[12] = '{0, 4'h0, 32'h0,         4'hF, 32'h0000_0006};
      vecs[13] = '{1, 4'hC, KICK,          4'hF, 32'h0};
      vecs[14] = '{0, 4'hC, 32'h0,         4'hF, 32'h0000_0000};
      vecs[15] = '{1, 4'h0, 32'h0000_0000, 4'hF, 32'h0};
      vecs[16] = '{0, 4'h0, 32'h0,         4'hF, 32'h0000_0000};

      rst_i = 1'b1; req_m = 1'b0; req_p = 1'b0; we = 1'b0;
      be = 4'h0; addr = '0; wdata = '0;
      idle(2);
      rst_i = 1'b0;
      check("rst_data_o", dout_m, 32'h0);
      check("rst_irq_o", {31'd0, irq_m}, 32'h0);
      check("rst_rst_req_o", {31'd0, rreq_m}, 32'h0);
      check("rst_p4_irq_rst", {30'd0, irq_p, rreq_p}, 32'h0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) bus_wr(1'b0, vecs[i].a, vecs[i].d, vecs[i].b);
         else begin
            bus_rd(1'b0, vecs[i].a, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
         end
      end

      // Expiry -> WARN -> RST with LOAD=3, PRESCALE=1; CTRL written at E0.
      bus_wr(1'b0, 4'h0, 32'h7, 4'hF);
      for (int k = 0; k < 4; k++) begin
         bus_rd(1'b0, 4'h8, rd);
         check($sformatf("a_count_e%0d", k), rd, 32'(3 - k));
      end
      check("a_irq_after_e4", {31'd0, irq_m}, 32'h1);
      check("a_rstreq_after_e4", {31'd0, rreq_m}, 32'h0);
      for (int k = 5; k < 8; k++) begin
         idle(1);
         check($sformatf("a_rstreq_e%0d", k), {31'd0, rreq_m}, 32'h0);
      end
      idle(1);
      check("a_rstreq_e8", {31'd0, rreq_m}, 32'h1);
      n_high = 1;
      for (int i = 0; i < 40; i++) begin
         idle(1);
         if (rreq_m) n_high++;
         else break;
      end
      check("a_pulse_len", 32'(n_high), 32'd16);
      bus_rd(1'b0, 4'h8, rd);
      check("a_count_after_rst", rd, 32'h3);
      bus_rd(1'b0, 4'hC, rd);
      check("a_status_after_rst", rd, 32'h4);

      // Disable, then clear the sticky WDRST flag.
      bus_wr(1'b0, 4'h0, 32'h0, 4'hF);
      check("b_irq_off", {31'd0, irq_m}, 32'h0);
      bus_rd(1'b0, 4'hC, rd);
      check("b_status_wdrst", rd, 32'h4);
      bus_wr(1'b0, 4'hC, CLR, 4'hF);
      bus_rd(1'b0, 4'hC, rd);
      check("b_status_cleared", rd, 32'h0);

      // Kick on the same edge as the expiry tick.
      bus_wr(1'b0, 4'h0, 32'h3, 4'hF);
      idle(3);
      bus_wr(1'b0, 4'hC, KICK, 4'hF);
      check("c_irq_at_kick", {31'd0, irq_m}, 32'h0);
      bus_rd(1'b0, 4'h8, rd);
      check("c_count_after_kick", rd, 32'h3);
      check("c_irq_next", {31'd0, irq_m}, 32'h0);
      bus_rd(1'b0, 4'hC, rd);
      check("c_status_no_pend", rd, 32'h0);
      check("c_irq_later", {31'd0, irq_m}, 32'h0);
      bus_wr(1'b0, 4'h0, 32'h0, 4'hF);

      // Lock: CTRL/LOAD frozen, unknown KEY ignored.
      bus_wr(1'b0, 4'h0, 32'h8, 4'hF);
      bus_wr(1'b0, 4'h0, 32'h0, 4'hF);
      bus_wr(1'b0, 4'h4, 32'h5, 4'hF);
      bus_rd(1'b0, 4'h0, rd);
      check("e_ctrl_locked", rd, 32'h8);
      bus_rd(1'b0, 4'h4, rd);
      check("e_load_locked", rd, 32'h3);
      bus_wr(1'b0, 4'hC, 32'h1234_5678, 4'hF);
      bus_rd(1'b0, 4'hC, rd);
      check("e_status_badkey", rd, 32'h2);

      // PRESCALE=4, LOAD=1: first expiry 8 cycles after enable, then disable in WARN.
      bus_wr(1'b1, 4'h4, 32'h1, 4'hF);
      bus_wr(1'b1, 4'h0, 32'h3, 4'hF);
      idle(7);
      check("d_irq_before_expiry", {31'd0, irq_p}, 32'h0);
      idle(1);
      check("d_irq_at_expiry", {31'd0, irq_p}, 32'h1);
      bus_wr(1'b1, 4'h0, 32'h2, 4'hF);
      check("d_irq_after_disable", {31'd0, irq_p}, 32'h0);
      bus_rd(1'b1, 4'h8, rd);
      check("d_count_is_load", rd, 32'h1);

      // rst_i in the middle of a reset pulse.
      bus_wr(1'b1, 4'h0, 32'h5, 4'hF);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         idle(1);
         if (rreq_p) begin found = 1'b1; break; end
      end
      check("f_pulse_seen", {31'd0, found}, 32'h1);
      idle(3);
      check("f_pulse_still_high", {31'd0, rreq_p}, 32'h1);
      rst_i = 1'b1;
      idle(1);
      rst_i = 1'b0;
      check("f_rstreq_dropped", {31'd0, rreq_p}, 32'h0);
      bus_rd(1'b1, 4'hC, rd);
      check("f_status_reset", rd, 32'h0);
      bus_rd(1'b0, 4'h0, rd);
      check("f_lock_cleared", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/wdt_top.md
# wdt_top

Watchdog timer peripheral attached as an additional slave on the SoC OBI interconnect, with the same register-port style as the timer and UART slaves. It counts down a software-loaded timeout and, if software fails to kick it, first raises an interrupt into the RVIC and then drives a reset request into the SoC reset generator, alongside the debug-module reset. It is clocked by the core clock and reset only by the external reset, so it survives the reset it causes.

## Interface
- PRESCALE, 1: core-clock cycles per count tick; legal range ≥1.
- DEFAULT_LOAD, 32'h00FF_FFFF: reset value of LOAD and COUNT.
- RST_PULSE, 16: length of the rst_req_o pulse in cycles; legal range ≥1.
- KICK_KEY, 32'h5A5A_A5A5: KEY value that reloads the counter.
- CLR_KEY, 32'hC1EA_C1EA: KEY value that clears the sticky WDRST flag.
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  bus request, valid for one cycle per access.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address; only [3:2] is decoded.
- data_i  in  32  write data.
- data_o  out  32  read data, registered.
- irq_o  out  1  level interrupt to the RVIC source input.
- rst_req_o  out  1  reset request pulse to the reset generator, active high.

## Operation
- Registers, selected by addr_i[3:2]:
  - 0x0 CTRL (RW): bit0 EN, bit1 IRQ_EN, bit2 RST_EN, bit3 LOCK. LOCK is set-only and clears only on rst_i.
  - 0x4 LOAD (RW): 32-bit timeout value.
  - 0x8 COUNT (RO): current counter. Writes are ignored.
  - 0xC: read returns STATUS = {29'b0, WDRST, LOCK, PEND}. A write is a KEY write.
- Write rules:
  - A write takes effect only if req_i & we_i & be_i==4'hF. Partial writes are ignored everywhere.
  - CTRL and LOAD writes are ignored while LOCK=1.
  - A KEY write with any value other than KICK_KEY or CLR_KEY is ignored.
- States:
  - IDLE: EN=0.
  - RUN: EN=1, PEND=0.
  - WARN: EN=1, PEND=1.
  - RST: pulse counter active.
- Tick generation:
  - A prescaler counts 0..PRESCALE-1 and emits a tick at wrap.
  - The prescaler clears on kick, on entering RUN, and in IDLE.
- Counting on each tick in RUN or WARN:
  - If COUNT==0, expiry: COUNT←LOAD.
  - Otherwise COUNT←COUNT-1.
  - Expiry period is therefore (LOAD+1)·PRESCALE cycles. LOAD=0 is legal and expires every tick.
- Transitions:
  - IDLE→RUN: CTRL write with EN=1. COUNT←LOAD in the same edge.
  - RUN→WARN: on expiry, PEND←1.
  - WARN→RST: on expiry, if RST_EN=1. WDRST←1 and the pulse counter loads RST_PULSE.
  - WARN→WARN: on expiry, if RST_EN=0.
  - RST→RUN: after RST_PULSE cycles. PEND←0, COUNT←LOAD, prescaler cleared.
  - Any state→IDLE: EN written 0. PEND←0, COUNT←LOAD, an in-progress rst_req_o pulse aborts immediately.
- Kick (KICK_KEY write) in RUN or WARN:
  - Effects: COUNT←LOAD, PEND←0, state←RUN, prescaler cleared.
  - A kick coinciding with an expiry tick wins; no expiry occurs.
  - A kick in IDLE or RST has no effect.
- A LOAD write while running takes effect at the next reload (kick or expiry); COUNT is not touched.
- A CLR_KEY write clears WDRST. If it coincides with setting WDRST, the set wins.
- irq_o = PEND & IRQ_EN, registered.
- rst_req_o is high exactly while in RST.

## Timing
- Reset values:
  - data_o=0, irq_o=0, rst_req_o=0.
  - CTRL=0, LOAD=COUNT=DEFAULT_LOAD, PEND=0, WDRST=0, prescaler=0.
  - State is IDLE.
- Reads:
  - data_o updates on the edge following req_i & ~we_i and holds until the next read.
  - Read latency is 1 cycle, matching the interconnect's rvalid timing.
  - A read of COUNT returns the value before that edge's decrement.
- Writes complete on the edge at which req_i is sampled. No wait states; the block always grants.
- irq_o and rst_req_o rise the cycle after the expiry edge that causes them. Both are glitch-free registered outputs.
- rst_i mid-pulse drops rst_req_o on the next edge; all state returns to reset values.

## Test plan
- Reset, then read all four offsets → 0x0, 0x00FF_FFFF, 0x00FF_FFFF, 0x0; irq_o=0, rst_req_o=0.
- PRESCALE=1, LOAD=3, CTRL=0x7 written at edge E0 → COUNT reads 3,2,1,0 after E0..E3; irq_o=1 after E4; rst_req_o=1 after E8 for exactly 16 cycles; then STATUS=0x4 and COUNT=3.
- LOAD=3, running, KICK_KEY written on the same edge as an expiry tick → PEND stays 0, COUNT=3, irq_o never asserts.
- CTRL=0x8 (lock), then write CTRL=0x0 and LOAD=5 → CTRL reads 0x8, LOAD unchanged. KEY write 0x1234_5678 → no effect.
- Write LOAD with be_i=4'h3 → ignored. CLR_KEY after a watchdog reset → STATUS bit2 clears.
- PRESCALE=4, LOAD=1 → first expiry 8 cycles after enable. Writing EN=0 during WARN → irq_o drops next cycle, COUNT reads LOAD.
